// File: rtl/uart_rx_sched_pkg.sv
// Shared definitions for the UART receive scheduler: FSM encoding and FIFO entry layout.
package uart_rx_sched_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAck  = 2'd1,
    StWait = 2'd2
  } state_e;

  localparam int unsigned EntryW  = 10;
  localparam int unsigned DataLsb = 0;
  localparam int unsigned DataMsb = 7;
  localparam int unsigned PerrBit = 8;
  localparam int unsigned FerrBit = 9;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO; the head entry is visible on rdata_o whenever valid_o is high.
module uart_rx_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 10,
  localparam int unsigned AddrW = $clog2(Depth),
  localparam int unsigned FillW = AddrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [FillW-1:0] fill_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic             push_fire, pop_fire;

  assign full_o    = (fill_q == FillW'(Depth));
  assign valid_o   = (fill_q != '0);
  assign push_fire = push_i & ~full_o;
  assign pop_fire  = pop_i & valid_o;
  assign fill_o    = fill_q;
  // Masked so an empty FIFO never exposes stale or uninitialised storage.
  assign rdata_o   = valid_o ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push_fire) wr_ptr_d = wr_ptr_q + AddrW'(1);
    if (pop_fire)  rd_ptr_d = rd_ptr_q + AddrW'(1);
    case ({push_fire, pop_fire})
      2'b10:   fill_d = fill_q + FillW'(1);
      2'b01:   fill_d = fill_q - FillW'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_fire) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_sched.sv
// UART receive scheduler: moves bytes from the receiver into a FIFO and tracks
// sticky errors, idle timeout and the combined interrupt.
module uart_rx_sched
  import uart_rx_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned IRQ_LEVEL     = 8,
  parameter int unsigned TIMEOUT_TICKS = 32,
  localparam int unsigned FillW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              baud_en_i,
  input  logic              rx_rdy_i,
  input  logic [7:0]        rx_data_i,
  input  logic              parity_err_i,
  input  logic              framing_err_i,
  input  logic              overflow_i,
  output logic              rx_read_o,
  input  logic              rd_en_i,
  output logic [EntryW-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic [FillW-1:0]  fill_o,
  input  logic              clr_err_i,
  input  logic              err_irq_en_i,
  output logic              sticky_perr_o,
  output logic              sticky_ferr_o,
  output logic              sticky_ovf_o,
  output logic              timeout_o,
  output logic              irq_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CntW-1:0]  TimeoutMax = CntW'(TIMEOUT_TICKS);
  localparam logic [FillW-1:0] IrqLvl     = FillW'(IRQ_LEVEL);

  state_e            state_q, state_d;
  logic              push, pop_fire, fifo_full;
  logic [EntryW-1:0] entry;
  logic [2:0]        err_flags, err_prev_q, sticky_q, sticky_d;
  logic [CntW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic              timeout_q, timeout_d, irq_q, irq_d;

  always_comb begin
    entry                  = '0;
    entry[DataMsb:DataLsb] = rx_data_i;
    entry[PerrBit]         = parity_err_i;
    entry[FerrBit]         = framing_err_i;
  end

  // Full is judged on the current fill, so a pop while full defers the push a cycle.
  assign push     = (state_q == StIdle) & rx_rdy_i & ~fifo_full;
  assign pop_fire = rd_en_i & rd_valid_o;

  uart_rx_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (EntryW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (entry),
    .pop_i   (rd_en_i),
    .rdata_o (rd_data_o),
    .valid_o (rd_valid_o),
    .full_o  (fifo_full),
    .fill_o  (fill_o)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (push) state_d = StAck;
      StAck:   state_d = StWait;
      StWait:  if (!rx_rdy_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Gated by reset so a reset landing in ACK never strobes the receiver.
  assign rx_read_o = (state_q == StAck) & ~rst_i;

  assign err_flags = {overflow_i, framing_err_i, parity_err_i};
  assign sticky_d  = (err_flags & ~err_prev_q) | (sticky_q & {3{~clr_err_i}});

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    timeout_d = timeout_q;
    if (push || pop_fire || fill_o == '0) begin
      tmo_cnt_d = '0;
    end else if (baud_en_i && tmo_cnt_q != TimeoutMax) begin
      tmo_cnt_d = tmo_cnt_q + CntW'(1);
    end
    if (pop_fire || fill_o == '0) begin
      timeout_d = 1'b0;
    end else if (tmo_cnt_q == TimeoutMax) begin
      timeout_d = 1'b1;
    end
  end

  assign irq_d = (fill_o >= IrqLvl) | timeout_q | (err_irq_en_i & (|sticky_q));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      err_prev_q <= '0;
      sticky_q   <= '0;
      tmo_cnt_q  <= '0;
      timeout_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_prev_q <= err_flags;
      sticky_q   <= sticky_d;
      tmo_cnt_q  <= tmo_cnt_d;
      timeout_q  <= timeout_d;
      irq_q      <= irq_d;
    end
  end

  assign sticky_perr_o = sticky_q[0];
  assign sticky_ferr_o = sticky_q[1];
  assign sticky_ovf_o  = sticky_q[2];
  assign timeout_o     = timeout_q;
  assign irq_o         = irq_q;

endmodule
